// File: rtl/add8_result_accumulator.sv
// add8 result accumulator.
// Sums BURST_LEN consecutive add8 results ({cout,sum}, 9 bits) into an ACC_W-bit
// total and presents the completed burst with a valid/ready handshake. The total
// wraps rather than saturating; overflow records any carry out of the top bit
// during the burst and stays set until the burst is consumed or cleared.
module add8_result_accumulator #(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned ACC_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       sum,
  input  logic             cout,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] total,
  output logic [7:0]       count,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned SumW      = ACC_W + 1;
  localparam logic [7:0]  LastCount = 8'(BURST_LEN);

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StHold
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] total_q, total_d;
  logic [7:0]       count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic [8:0]       value;
  logic [SumW-1:0]  acc_sum;
  logic [7:0]       count_inc;

  // Only a registered in_ready can gate an accept, so sum/cout are never
  // looked at while in_valid is low or the block is holding a result.
  assign accept    = in_valid & in_ready_q;
  assign value     = {cout, sum};
  assign acc_sum   = {1'b0, total_q} + SumW'(value);
  assign count_inc = count_q + 8'd1;

  // Next-state logic: clear beats everything, then accept / out handshake.
  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (clear) begin
      state_d    = StIdle;
      total_d    = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            total_d    = ACC_W'(value);
            count_d    = 8'd1;
            overflow_d = 1'b0;
            state_d    = (LastCount == 8'd1) ? StHold : StAccum;
          end
        end
        StAccum: begin
          if (accept) begin
            total_d    = acc_sum[ACC_W-1:0];
            count_d    = count_inc;
            overflow_d = overflow_q | acc_sum[ACC_W];
            state_d    = (count_inc == LastCount) ? StHold : StAccum;
          end
        end
        StHold: begin
          if (out_ready) begin
            state_d    = StIdle;
            total_d    = '0;
            count_d    = '0;
            overflow_d = 1'b0;
          end
        end
        default: begin
          state_d    = StIdle;
          total_d    = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      endcase
    end
  end

  // Handshake outputs are registered from the next state so they change on the
  // same edge as the state. in_ready stays low through reset and rises on the
  // first edge after release.
  always_comb begin
    in_ready_d  = (state_d != StHold);
    out_valid_d = (state_d == StHold);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      total_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      total_q     <= total_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign total     = total_q;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_add8_result_accumulator.sv
// Directed bench for add8_result_accumulator: a default instance driven from a
// vector table plus hand sequences, and a 9-bit / 2-result instance for wrap.
module tb_add8_result_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;

  // Default instance (BURST_LEN=4, ACC_W=16).
  logic [7:0]  sum;
  logic        cout, in_valid, clear, out_ready;
  logic        in_ready, overflow, out_valid;
  logic [15:0] total;
  logic [7:0]  count;

  // Narrow instance (BURST_LEN=2, ACC_W=9).
  logic [7:0]  b_sum;
  logic        b_cout, b_in_valid, b_clear, b_out_ready;
  logic        b_in_ready, b_overflow, b_out_valid;
  logic [8:0]  b_total;
  logic [7:0]  b_count;

  int total_n = 0;
  int bad_n   = 0;

  always #5 clk = ~clk;

  add8_result_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sum       (sum),
    .cout      (cout),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .clear     (clear),
    .total     (total),
    .count     (count),
    .overflow  (overflow),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  add8_result_accumulator #(
    .BURST_LEN (2),
    .ACC_W     (9)
  ) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .sum       (b_sum),
    .cout      (b_cout),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .clear     (b_clear),
    .total     (b_total),
    .count     (b_count),
    .overflow  (b_overflow),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready)
  );

  typedef struct {
    logic        v;
    logic [7:0]  s;
    logic        c;
    logic        clr;
    logic        ordy;
    logic        ir;
    logic        ov;
    logic [15:0] tot;
    logic [7:0]  cnt;
    logic        ovf;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ir, input logic ov,
                         input logic [15:0] tot, input logic [7:0] cnt, input logic ovf);
    chk({tag, ".in_ready"},  32'(in_ready),  32'(ir));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".total"},     32'(total),     32'(tot));
    chk({tag, ".count"},     32'(count),     32'(cnt));
    chk({tag, ".overflow"},  32'(overflow),  32'(ovf));
  endtask

  task automatic drive(input logic v, input logic [7:0] s, input logic c,
                       input logic clr, input logic ordy);
    in_valid  = v;
    sum       = s;
    cout      = c;
    clear     = clr;
    out_ready = ordy;
  endtask

  // Advance one edge and sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Stimulus table: inputs applied before an edge, expectations after it.
    //            v   s      c  clr ordy  ir ov tot        cnt   ovf
    tbl[0]  = '{1, 8'hFF, 0, 0, 0,   1, 0, 16'h00FF, 8'd1, 0};
    tbl[1]  = '{1, 8'hFF, 0, 0, 0,   1, 0, 16'h01FE, 8'd2, 0};
    tbl[2]  = '{1, 8'hFF, 0, 0, 0,   1, 0, 16'h02FD, 8'd3, 0};
    tbl[3]  = '{1, 8'hFF, 0, 0, 0,   0, 1, 16'h03FC, 8'd4, 0};
    tbl[4]  = '{1, 8'h11, 0, 0, 0,   0, 1, 16'h03FC, 8'd4, 0};  // hold ignores in_valid
    tbl[5]  = '{1, 8'h22, 1, 0, 1,   1, 0, 16'h0000, 8'd0, 0};  // handshake, no accept
    tbl[6]  = '{1, 8'h01, 0, 0, 0,   1, 0, 16'h0001, 8'd1, 0};
    tbl[7]  = '{0, 8'hEE, 1, 0, 0,   1, 0, 16'h0001, 8'd1, 0};  // gap, junk data
    tbl[8]  = '{1, 8'h01, 0, 0, 0,   1, 0, 16'h0002, 8'd2, 0};
    tbl[9]  = '{1, 8'h05, 0, 1, 1,   1, 0, 16'h0000, 8'd0, 0};  // clear beats accept
    tbl[10] = '{1, 8'h01, 0, 0, 0,   1, 0, 16'h0001, 8'd1, 0};
    tbl[11] = '{1, 8'h01, 0, 0, 0,   1, 0, 16'h0002, 8'd2, 0};
    tbl[12] = '{1, 8'h01, 0, 0, 0,   1, 0, 16'h0003, 8'd3, 0};
    tbl[13] = '{1, 8'h01, 0, 0, 0,   0, 1, 16'h0004, 8'd4, 0};
    tbl[14] = '{0, 8'h00, 0, 1, 0,   1, 0, 16'h0000, 8'd0, 0};  // clear in hold
    tbl[15] = '{1, 8'h80, 1, 0, 0,   1, 0, 16'h0180, 8'd1, 0};
    tbl[16] = '{1, 8'h80, 1, 0, 0,   1, 0, 16'h0300, 8'd2, 0};
    tbl[17] = '{0, 8'h00, 0, 1, 0,   1, 0, 16'h0000, 8'd0, 0};

    rst_n = 1'b0;
    drive(0, 8'h00, 0, 0, 0);
    b_in_valid = 0; b_sum = 0; b_cout = 0; b_clear = 0; b_out_ready = 0;
    #3;
    chk_all("reset", 0, 0, 16'h0, 8'd0, 0);
    step();
    chk_all("reset_edge", 0, 0, 16'h0, 8'd0, 0);
    rst_n = 1'b1;
    #1;
    chk("post_release.in_ready", 32'(in_ready), 32'd0);
    step();
    chk("first_edge.in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].c, tbl[i].clr, tbl[i].ordy);
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].ir, tbl[i].ov, tbl[i].tot, tbl[i].cnt, tbl[i].ovf);
    end

    // 0x1FF accepts with two-cycle gaps of junk data.
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'hFF, 1, 0, 0);
      step();
      chk($sformatf("gap_acc%0d.count", i), 32'(count), 32'(i + 1));
      for (int g = 0; g < 2; g++) begin
        drive(0, 8'h5A, 1, 0, 0);
        step();
        chk($sformatf("gap%0d_%0d.total", i, g), 32'(total), 32'((i + 1) * 'h1FF));
      end
    end
    chk_all("gaps_done", 0, 1, 16'h07FC, 8'd4, 0);

    // Hold for 5 cycles against in_valid, then consume.
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'h33, 0, 0, 0);
      step();
      chk_all($sformatf("hold%0d", i), 0, 1, 16'h07FC, 8'd4, 0);
    end
    drive(0, 8'h00, 0, 0, 1);
    step();
    chk_all("consume", 1, 0, 16'h0, 8'd0, 0);

    // Back-to-back bursts with out_ready held high.
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'h02, 0, 0, 1);
      step();
    end
    chk_all("b2b_full", 0, 1, 16'h0008, 8'd4, 0);
    drive(1, 8'h03, 0, 0, 1);
    step();
    chk_all("b2b_drain", 1, 0, 16'h0, 8'd0, 0);
    drive(1, 8'h03, 0, 0, 1);
    step();
    chk_all("b2b_next", 1, 0, 16'h0003, 8'd1, 0);
    drive(0, 8'h00, 0, 1, 0);
    step();

    // Narrow instance: 0x1FF + 0x001 wraps to 0 with overflow.
    b_in_valid = 1; b_sum = 8'hFF; b_cout = 1;
    step();
    chk("w9_1.total", 32'(b_total), 32'h1FF);
    chk("w9_1.overflow", 32'(b_overflow), 32'd0);
    b_sum = 8'h01; b_cout = 0;
    step();
    b_in_valid = 0;
    chk("w9_2.total", 32'(b_total), 32'h000);
    chk("w9_2.overflow", 32'(b_overflow), 32'd1);
    chk("w9_2.count", 32'(b_count), 32'd2);
    chk("w9_2.out_valid", 32'(b_out_valid), 32'd1);
    b_out_ready = 1;
    step();
    b_out_ready = 0;
    chk("w9_done.overflow", 32'(b_overflow), 32'd0);
    chk("w9_done.in_ready", 32'(b_in_ready), 32'd1);

    // Reset pulse between edges after 3 accepts.
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'h10, 0, 0, 0);
      step();
    end
    chk("pre_rst.total", 32'(total), 32'h30);
    drive(0, 8'h00, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    chk_all("async_rst", 0, 0, 16'h0, 8'd0, 0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("rst_release.in_ready", 32'(in_ready), 32'd0);
    step();
    chk("rst_first_edge.in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'(8'h20 + i), 0, 0, 0);
      step();
    end
    drive(0, 8'h00, 0, 0, 0);
    chk_all("after_rst", 0, 1, 16'h0086, 8'd4, 0);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
